alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer_if.sv | 35 +++
 rtl/alu_cmd_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command, ALU and response signals of alu_cmd_sequencer
// slave is the sequencer's view; master is the surrounding environment.
interface alu_cmd_sequencer_if #(
  parameter int DATA_W = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_W-1:0]     cmd_a;
  logic [DATA_W-1:0]     cmd_b;
  logic [2:0]            cmd_op;
  logic [DATA_W-1:0]     alu_a;
  logic [DATA_W-1:0]     alu_b;
  logic [2:0]            alu_op;
  logic                  alu_start;
  logic                  alu_done;
  logic [2*DATA_W-1:0]   alu_result;
  logic                  alu_rst_n;
  logic                  rsp_valid;
  logic [2*DATA_W-1:0]   rsp_result;
  logic [2:0]            rsp_op;
  logic                  rsp_timeout;
  logic                  busy;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result,
    output cmd_ready, alu_a, alu_b, alu_op, alu_start, alu_rst_n,
           rsp_valid, rsp_result, rsp_op, rsp_timeout, busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result,
    input  cmd_ready, alu_a, alu_b, alu_op, alu_start, alu_rst_n,
           rsp_valid, rsp_result, rsp_op, rsp_timeout, busy
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command FIFO feeding a multi-cycle ALU, one response per computing op
// Optional WAIT abort after TIMEOUT cycles is enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_cmd_sequencer #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  alu_cmd_sequencer_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2*DATA_W + 3;

  typedef enum logic [2:0] {IDLE, NOP, WAIT, RESP, ARST} state_t;

  state_t                state, state_nxt;
  logic [ENT_W-1:0]      mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full, empty, push, pop;
  logic [DATA_W-1:0]     head_a, head_b;
  logic [2:0]            head_op;
  logic                  arst_cnt;
  logic [DATA_W-1:0]     a_q, b_q;
  logic [2:0]            op_q, rsp_op_q;
  logic [2*DATA_W-1:0]   res_q;
  logic                  timeout_hit, to_flag;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.cmd_valid && bus.cmd_ready;
  assign pop   = (state == IDLE) && !empty;
  assign {head_op, head_b, head_a} = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.cmd_op, bus.cmd_b, bus.cmd_a};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] wait_cnt;

  // alu_done on the final count wins over the abort.
  assign timeout_hit = (state == WAIT) && !bus.alu_done && (wait_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      to_flag  <= 1'b0;
    end else begin
      wait_cnt <= (state == WAIT) ? wait_cnt + TO_W'(1) : '0;
      if (state == WAIT) to_flag <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign to_flag     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!empty) begin
        case (head_op)
          3'b111:                         state_nxt = ARST;
          3'b001, 3'b010, 3'b011, 3'b100: state_nxt = WAIT;
          default:                        state_nxt = NOP;
        endcase
      end
      NOP:     state_nxt = IDLE;
      WAIT:    if (bus.alu_done || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = to_flag ? ARST : IDLE;
      ARST:    if (arst_cnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arst_cnt <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      res_q    <= '0;
      rsp_op_q <= '0;
    end else begin
      arst_cnt <= (state == ARST) ? !arst_cnt : 1'b0;
      if (pop) begin
        a_q  <= head_a;
        b_q  <= head_b;
        op_q <= head_op;
      end
      if ((state == WAIT) && (bus.alu_done || timeout_hit)) begin
        res_q    <= bus.alu_done ? bus.alu_result : '0;
        rsp_op_q <= op_q;
      end
    end
  end

  always_comb begin
    bus.alu_start   = (state == NOP) || (state == WAIT);
    bus.rsp_valid   = (state == RESP);
    bus.rsp_timeout = (state == RESP) && to_flag;
    bus.alu_rst_n   = reset_n && (state != ARST);
    bus.cmd_ready   = reset_n && !full;
    bus.busy        = reset_n && ((state != IDLE) || !empty);
  end

  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_op     = rsp_op_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - randomized directed bench with ALU model and response scoreboard
module tb_alu_cmd_sequencer;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  typedef struct packed {
    logic [2:0]      op;
    logic [2*DW-1:0] res;
    logic            to;
  } rsp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.DATA_W(DW)) bus();

  alu_cmd_sequencer #(.DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  rsp_t got[$];
  rsp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   start_cycles = 0, start_rises = 0, rst_low = 0;
  int   fixed_lat = -1;
  bit   stall = 1'b0;

  function automatic logic [2*DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] xa, xb;
    xa = {{DW{1'b0}}, a};
    xb = {{DW{1'b0}}, b};
    case (op)
      3'd1:    return xa + xb;
      3'd2:    return xa & xb;
      3'd3:    return xa ^ xb;
      3'd4:    return xa * xb;
      default: return '0;
    endcase
  endfunction

  function automatic bit responds(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

  // ALU model: answers computing ops after a latency, holds done for one cycle.
  initial begin
    int cnt, lat;
    cnt = 0;
    lat = 0;
    bus.alu_done = 1'b0;
    bus.alu_result = '0;
    forever begin
      @(negedge clk);
      if (!bus.alu_rst_n || bus.alu_done) begin
        bus.alu_done = 1'b0;
        cnt = 0;
        lat = $urandom_range(0, 3);
      end else if (bus.alu_start && responds(bus.alu_op) && !stall) begin
        if (cnt >= ((fixed_lat >= 0) ? fixed_lat : lat)) begin
          bus.alu_done = 1'b1;
          bus.alu_result = ref_alu(bus.alu_op, bus.alu_a, bus.alu_b);
        end else begin
          cnt++;
        end
      end
    end
  end

  initial begin
    rsp_t r;
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.rsp_valid) begin
          r.op = bus.rsp_op;
          r.res = bus.rsp_result;
          r.to = bus.rsp_timeout;
          got.push_back(r);
        end
        if (bus.alu_start) start_cycles++;
        if (bus.alu_start && !prev_start) start_rises++;
        if (!bus.alu_rst_n) rst_low++;
      end
      prev_start = bus.alu_start;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_stats();
    @(posedge clk);
    start_cycles = 0;
    start_rises = 0;
    rst_low = 0;
  endtask

  task automatic push(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, output int waited);
    rsp_t e;
    waited = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_a = a;
    bus.cmd_b = b;
    while (!bus.cmd_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    if (responds(op)) begin
      e.op = op;
      e.res = ref_alu(op, a, b);
      e.to = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 32'(n < 2000), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_rsps(input string tag);
    rsp_t g, e;
    check({tag, "_rsp_count"}, got.size(), exp_q.size());
    while (got.size() > 0 && exp_q.size() > 0) begin
      g = got.pop_front();
      e = exp_q.pop_front();
      check({tag, "_rsp"}, 32'(g), 32'(e));
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    int w, wsum, n_rst, n_start, n;
    logic [2:0] op;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_alu_rst_n", bus.alu_rst_n, 0);
    check("rst_alu_start", bus.alu_start, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_timeout", bus.rsp_timeout, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_op", bus.alu_op, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_rsp_op", bus.rsp_op, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", bus.cmd_ready, 1);
    check("post_rst_alu_rst_n", bus.alu_rst_n, 1);

    // add FF+01, done after one cycle, start latency of 2
    fixed_lat = 0;
    clear_stats();
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd1; bus.cmd_a = 8'hFF; bus.cmd_b = 8'h01;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    exp_q.push_back(rsp_t'({3'd1, 16'h0100, 1'b0}));
    @(negedge clk);
    check("add_start_lat1", bus.alu_start, 0);
    @(negedge clk);
    check("add_start_lat2", bus.alu_start, 1);
    wait_idle("add");
    check("add_start_cycles", start_cycles, 1);
    compare_rsps("add");

    // fill with a stalled ALU, then a sixth command once it drains
    fixed_lat = -1;
    stall = 1'b1;
    wsum = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      push(3'(1 + $urandom_range(0, 3)), 8'($urandom), 8'($urandom), w);
      wsum += w;
    end
    check("fill_no_wait", wsum, 0);
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd4; bus.cmd_a = 8'($urandom); bus.cmd_b = 8'($urandom);
    for (int i = 0; i < 3; i++) begin
      check("full_cmd_ready", bus.cmd_ready, 0);
      @(negedge clk);
    end
    check("full_busy", bus.busy, 1);
    stall = 1'b0;
    n = 0;
    while (!bus.cmd_ready && n < 500) begin @(negedge clk); n++; end
    check("sixth_accepted", 32'(n < 500), 1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    exp_q.push_back(rsp_t'({bus.cmd_op, ref_alu(bus.cmd_op, bus.cmd_a, bus.cmd_b), 1'b0}));
    wait_idle("fill");
    compare_rsps("fill");

    // no_op, rst_op, mul 10*10
    fixed_lat = 0;
    clear_stats();
    push(3'd0, 8'h12, 8'h34, w);
    push(3'd7, 8'h00, 8'h00, w);
    push(3'd4, 8'h10, 8'h10, w);
    wait_idle("seq");
    check("seq_rst_low", rst_low, 2);
    check("seq_start_rises", start_rises, 2);
    check("seq_start_cycles", start_cycles, 2);
    check("seq_mul_res", (got.size() > 0) ? got[0].res : 16'hxxxx, 16'h0100);
    compare_rsps("seq");

    // illegal opcode 110 behaves as no_op
    clear_stats();
    push(3'd6, 8'd3, 8'd4, w);
    wait_idle("ill");
    check("ill_start_cycles", start_cycles, 1);
    check("ill_rsp_count", got.size(), 0);
    check("ill_rst_low", rst_low, 0);

    // random command stream
    fixed_lat = -1;
    clear_stats();
    n_rst = 0;
    n_start = 0;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd7) n_rst++; else n_start++;
      push(op, 8'($urandom), 8'($urandom), w);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle("rand");
    check("rand_start_rises", start_rises, n_start);
    check("rand_rst_low", rst_low, 2 * n_rst);
    compare_rsps("rand");

    // reset during WAIT with two queued commands
    stall = 1'b1;
    for (int i = 0; i < 3; i++) push(3'd1, 8'($urandom), 8'($urandom), w);
    n = 0;
    while (!bus.alu_start && n < 100) begin @(negedge clk); n++; end
    check("mid_wait_reached", 32'(n < 100), 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_alu_start", bus.alu_start, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 0);
    check("mid_rst_alu_rst_n", bus.alu_rst_n, 0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    stall = 1'b0;
    clear_stats();
    repeat (5) @(negedge clk);
    check("mid_rst_no_rsp", got.size(), 0);
    check("mid_rst_idle", bus.busy, 0);
    check("mid_rst_no_start", start_cycles, 0);
    push(3'd3, 8'hA5, 8'h0F, w);
    wait_idle("after_rst");
    compare_rsps("after_rst");

`ifdef ALU_SEQ_TIMEOUT_EN
    stall = 1'b1;
    clear_stats();
    push(3'd1, 8'd5, 8'd6, w);
    wait_idle("tmo");
    stall = 1'b0;
    check("tmo_rsp_count", got.size(), 1);
    check("tmo_rsp", (got.size() > 0) ? 32'(got[0]) : 32'hxxxx, 32'(rsp_t'({3'd1, 16'h0000, 1'b1})));
    check("tmo_wait_cycles", start_cycles, TMO);
    check("tmo_rst_low", rst_low, 2);
    got.delete();
    exp_q.delete();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
